// File: rtl/led_matrix_scan.sv
// Row-multiplexed scan driver for a serial-shift-register LED matrix.
// Snapshots the frame at row 0, shifts one row's columns plus a walking row bit, latches, then dwells.
`timescale 1ns/1ps
module led_matrix_scan #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int DWELL_W = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] frame,
    output logic                 frame_sync,
    output logic                 csdi,
    output logic                 cclk,
    output logic                 rsdi,
    output logic                 rclk,
    output logic                 le,
    output logic                 oeb
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IDX_W = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1;
    localparam int SH_W  = $clog2(2 * ((ROWS > COLS) ? ROWS : COLS));
    localparam int CNT_W = (SH_W > DWELL_W) ? SH_W : DWELL_W;

    localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(2*ROWS - 1);
    localparam logic [CNT_W-1:0] COL_END   = CNT_W'(2*COLS - 1);
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'((1 << DWELL_W) - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE, FLUSH, BLANK, SHIFT_COL, SHIFT_ROW, LATCH, DISPLAY
    } state_t;

    state_t                 state;
    logic [ROW_W-1:0]       row;
    logic [CNT_W-1:0]       cnt;
    logic [ROWS*COLS-1:0]   snap;

    logic [CNT_W-1:0]       cnt_nx;
    logic [COL_W-1:0]       col_sel;
    logic [IDX_W-1:0]       bit_idx;
    logic [ROWS*COLS-1:0]   src;
    logic                   nxt_bit;

    // Column for the next cycle-A slot; cnt is 0 in BLANK so this also yields COLS-1 there.
    assign cnt_nx  = cnt + CNT_W'(1);
    assign col_sel = COL_W'(COLS - 1) - COL_W'(cnt_nx >> 1);
    assign bit_idx = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col_sel);
    // The first bit of row 0 is launched in the same cycle the snapshot is taken.
    assign src     = (state == BLANK && row == '0) ? frame : snap;
    assign nxt_bit = src[bit_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            row        <= '0;
            cnt        <= '0;
            snap       <= '0;
            frame_sync <= 1'b0;
            csdi       <= 1'b0;
            cclk       <= 1'b0;
            rsdi       <= 1'b0;
            rclk       <= 1'b0;
            le         <= 1'b0;
            oeb        <= 1'b1;
        end else begin
            frame_sync <= 1'b0;
            le         <= 1'b0;
            case (state)
                IDLE: begin
                    oeb <= 1'b1;
                    if (enable) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end
                end
                FLUSH: begin
                    if (cnt == FLUSH_END) begin
                        state      <= BLANK;
                        row        <= '0;
                        cnt        <= '0;
                        rclk       <= 1'b0;
                        frame_sync <= 1'b1;
                    end else begin
                        cnt  <= cnt_nx;
                        rclk <= cnt_nx[0];
                    end
                end
                BLANK: begin
                    if (row == '0) snap <= frame;
                    state <= SHIFT_COL;
                    cnt   <= '0;
                    csdi  <= nxt_bit;
                    cclk  <= 1'b0;
                end
                SHIFT_COL: begin
                    if (cnt == COL_END) begin
                        state <= SHIFT_ROW;
                        cnt   <= '0;
                        cclk  <= 1'b0;
                        csdi  <= 1'b0;
                        rsdi  <= (row == '0);
                        rclk  <= 1'b0;
                    end else begin
                        cnt  <= cnt_nx;
                        cclk <= cnt_nx[0];
                        if (!cnt_nx[0]) csdi <= nxt_bit;
                    end
                end
                SHIFT_ROW: begin
                    if (cnt == '0) begin
                        cnt  <= cnt_nx;
                        rclk <= 1'b1;
                    end else begin
                        state <= LATCH;
                        cnt   <= '0;
                        rclk  <= 1'b0;
                        rsdi  <= 1'b0;
                        le    <= 1'b1;
                    end
                end
                LATCH: begin
                    state <= DISPLAY;
                    oeb   <= 1'b0;
                end
                DISPLAY: begin
                    if (cnt == DWELL_END) begin
                        cnt <= '0;
                        oeb <= 1'b1;
                        if (row != ROW_LAST) begin
                            row   <= row + ROW_W'(1);
                            state <= BLANK;
                        end else begin
                            row <= '0;
                            if (enable) begin
                                state      <= BLANK;
                                frame_sync <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: models the off-chip shift/latch chains and compares what the
// matrix would show, plus scan timing, against the frame that was applied.
`timescale 1ns/1ps
module tb_led_matrix_scan;
    localparam int ROWS = 8, COLS = 8, DWELL_W = 5, N = ROWS*COLS;
    localparam int DWELL = 1 << DWELL_W;
    localparam int P     = 2*COLS + 4 + DWELL;
    localparam int LEAD  = 1 + 2*ROWS;

    logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic [N-1:0] frame = '0;
    logic frame_sync, csdi, cclk, rsdi, rclk, le, oeb;

    int vectors = 0, errors = 0;
    int cyc = 0;

    typedef struct {
        logic [ROWS-1:0] rows;
        logic [COLS-1:0] cols;
        int              gap;
    } disp_t;

    disp_t disp_q[$];
    int    dwell_q[$];
    logic  cbit_q[$];
    logic  rbit_q[$];
    int    fs_cnt = 0, fs_last = 0, fs_prev = 0, le_cnt = 0, last_le = 0, run = 0;
    logic [COLS-1:0] col_chain = '0, col_lat = '0;
    logic [ROWS-1:0] row_chain = '0, row_lat = '0;
    logic p_cclk = 1'b0, p_rclk = 1'b0, p_oeb = 1'b1;

    led_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .DWELL_W(DWELL_W)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .frame(frame),
        .frame_sync(frame_sync), .csdi(csdi), .cclk(cclk), .rsdi(rsdi),
        .rclk(rclk), .le(le), .oeb(oeb)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // External hardware model: shift on rising cclk/rclk, latch on le, record what is lit.
    always @(negedge clock) begin
        if (cclk && !p_cclk) begin
            cbit_q.push_back(csdi);
            col_chain <= {col_chain[COLS-2:0], csdi};
        end
        if (rclk && !p_rclk) begin
            rbit_q.push_back(rsdi);
            row_chain <= {row_chain[ROWS-2:0], rsdi};
        end
        if (le) begin
            le_cnt  <= le_cnt + 1;
            col_lat <= col_chain;
            row_lat <= row_chain;
            last_le <= cyc;
        end
        if (!oeb && p_oeb) begin
            disp_q.push_back('{row_lat, col_lat, cyc - last_le});
            run <= 1;
        end else if (!oeb) begin
            run <= run + 1;
        end
        if (oeb && !p_oeb) dwell_q.push_back(run);
        if (frame_sync) begin
            fs_cnt  <= fs_cnt + 1;
            fs_prev <= fs_last;
            fs_last <= cyc;
        end
        p_cclk <= cclk;
        p_rclk <= rclk;
        p_oeb  <= oeb;
    end

    // Order in which a frame's pixels leave on csdi: rows ascending, columns high to low.
    function automatic logic [N-1:0] shift_order(input logic [N-1:0] f);
        logic [N-1:0] s;
        s = '0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                s[r*COLS + k] = f[r*COLS + COLS-1-k];
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // what: 0 frame_sync count, 1 display count, 2 dwell count, 3 cclk high, 4 oeb low
    task automatic wait_for(input int what, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clock);
            #1;
            case (what)
                0: ok = (fs_cnt >= target);
                1: ok = (disp_q.size() >= target);
                2: ok = (dwell_q.size() >= target);
                3: ok = (cclk === 1'b1);
                default: ok = (oeb === 1'b0);
            endcase
        end
    endtask

    task automatic test_reset();
        bit ok;
        int k, rb, n;
        logic [ROWS-1:0] bits;
        reset_n = 1'b0;
        enable  = 1'b1;
        frame   = {$urandom, $urandom};
        tick(3);
        vectors++;
        if ({oeb, frame_sync, csdi, cclk, rsdi, rclk, le} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b",
                     {oeb, frame_sync, csdi, cclk, rsdi, rclk, le}, 7'b1000000);
        end
        rb = rbit_q.size();
        k  = cyc;
        reset_n = 1'b1;
        wait_for(0, fs_cnt + 1, 100, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_first_sync: got timeout want frame_sync");
        end
        vectors++;
        if (fs_last - k !== LEAD) begin
            errors++;
            $display("FAIL reset_lead: got %0d want %0d", fs_last - k, LEAD);
        end
        n = rbit_q.size() - rb;
        bits = '0;
        for (int i = 0; i < n && i < ROWS; i++) bits[i] = rbit_q[rb+i];
        vectors++;
        if (n !== ROWS || bits !== '0) begin
            errors++;
            $display("FAIL reset_flush: got %0d edges bits %b want %0d zeros", n, bits, ROWS);
        end
    endtask

    task automatic test_single_pixel();
        bit ok;
        int cb, db, n;
        logic [N-1:0] got;
        frame = '0;
        frame[2*COLS + 5] = 1'b1;
        wait_for(0, fs_cnt + 1, 2*P*ROWS, ok);
        cb = cbit_q.size();
        db = disp_q.size();
        wait_for(0, fs_cnt + 1, 2*P*ROWS, ok);
        n = cbit_q.size() - cb;
        got = '0;
        for (int i = 0; i < n && i < N; i++) got[i] = cbit_q[cb+i];
        vectors++;
        if (!ok || n !== N || got !== shift_order(frame) || $countones(got) !== 1) begin
            errors++;
            $display("FAIL pixel_stream: got %0d bits %h want %0d bits %h", n, got, N, shift_order(frame));
        end
        vectors++;
        if (disp_q[db+2].cols !== COLS'(1 << 5) || disp_q[db+2].rows !== ROWS'(1 << 2)) begin
            errors++;
            $display("FAIL pixel_row2: got rows %b cols %b want rows %b cols %b",
                     disp_q[db+2].rows, disp_q[db+2].cols, ROWS'(1 << 2), COLS'(1 << 5));
        end
    endtask

    task automatic test_row_walk();
        bit ok;
        int cb, db, rb, wb, lb, n, bad;
        logic [N-1:0] got;
        logic [ROWS-1:0] rbits, er;
        for (int t = 0; t < 3; t++) begin
            frame = {$urandom, $urandom};
            wait_for(0, fs_cnt + 1, 2*P*ROWS, ok);
            cb = cbit_q.size(); db = disp_q.size(); rb = rbit_q.size();
            wb = dwell_q.size(); lb = le_cnt;
            wait_for(0, fs_cnt + 1, 2*P*ROWS, ok);
            vectors++;
            if (!ok || fs_last - fs_prev !== ROWS*P) begin
                errors++;
                $display("FAIL walk_period: got %0d want %0d", fs_last - fs_prev, ROWS*P);
            end
            vectors++;
            if (le_cnt - lb !== ROWS) begin
                errors++;
                $display("FAIL walk_le_count: got %0d want %0d", le_cnt - lb, ROWS);
            end
            n = rbit_q.size() - rb;
            rbits = '0;
            for (int i = 0; i < n && i < ROWS; i++) rbits[i] = rbit_q[rb+i];
            vectors++;
            if (n !== ROWS || rbits !== ROWS'(1)) begin
                errors++;
                $display("FAIL walk_rsdi: got %0d edges %b want %0d edges %b", n, rbits, ROWS, ROWS'(1));
            end
            n = cbit_q.size() - cb;
            got = '0;
            for (int i = 0; i < n && i < N; i++) got[i] = cbit_q[cb+i];
            vectors++;
            if (n !== N || got !== shift_order(frame)) begin
                errors++;
                $display("FAIL walk_stream: got %0d bits %h want %h", n, got, shift_order(frame));
            end
            bad = 0;
            for (int r = 0; r < ROWS; r++) begin
                er = ROWS'(1) << r;
                if (disp_q.size() < db + ROWS || dwell_q.size() < wb + ROWS) bad++;
                else if (disp_q[db+r].rows !== er || disp_q[db+r].cols !== frame[r*COLS +: COLS] ||
                         disp_q[db+r].gap !== 1 || dwell_q[wb+r] !== DWELL) bad++;
            end
            vectors++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL walk_display: got %0d bad rows want 0", bad);
            end
        end
    endtask

    task automatic test_snapshot();
        bit ok;
        int cb, db, n;
        logic [N-1:0] got;
        frame = '1;
        wait_for(0, fs_cnt + 1, 2*P*ROWS, ok);
        cb = cbit_q.size();
        db = disp_q.size();
        wait_for(1, db + 4, 2*P*ROWS, ok);
        frame = '0;
        wait_for(0, fs_cnt + 1, 2*P*ROWS, ok);
        n = cbit_q.size() - cb;
        got = '0;
        for (int i = 0; i < n && i < N; i++) got[i] = cbit_q[cb+i];
        vectors++;
        if (!ok || n !== N || got !== {N{1'b1}}) begin
            errors++;
            $display("FAIL snapshot_hold: got %0d bits %h want all ones", n, got);
        end
        cb = cbit_q.size();
        wait_for(0, fs_cnt + 1, 2*P*ROWS, ok);
        n = cbit_q.size() - cb;
        got = '1;
        for (int i = 0; i < n && i < N; i++) got[i] = cbit_q[cb+i];
        vectors++;
        if (!ok || n !== N || got !== '0) begin
            errors++;
            $display("FAIL snapshot_next: got %0d bits %h want all zeros", n, got);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int cb, db, rb, wb, lb, fb, k, n;
        logic [N-1:0] got;
        logic [ROWS-1:0] rbits;
        frame = {$urandom, $urandom};
        wait_for(0, fs_cnt + 1, 2*P*ROWS, ok);
        cb = cbit_q.size(); db = disp_q.size(); rb = rbit_q.size();
        wb = dwell_q.size(); lb = le_cnt;
        wait_for(1, db + 2, 2*P, ok);
        enable = 1'b0;
        fb = fs_cnt;
        wait_for(2, wb + ROWS, 2*P*ROWS, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_complete: got timeout want %0d rows", ROWS);
        end
        tick(100);
        n = cbit_q.size() - cb;
        got = '0;
        for (int i = 0; i < n && i < N; i++) got[i] = cbit_q[cb+i];
        vectors++;
        if (n !== N || got !== shift_order(frame)) begin
            errors++;
            $display("FAIL drop_stream: got %0d bits %h want %0d bits %h", n, got, N, shift_order(frame));
        end
        vectors++;
        if (rbit_q.size() - rb !== ROWS || le_cnt - lb !== ROWS || fs_cnt !== fb || oeb !== 1'b1) begin
            errors++;
            $display("FAIL drop_idle: got rclk %0d le %0d syncs %0d oeb %b want %0d %0d 0 1",
                     rbit_q.size() - rb, le_cnt - lb, fs_cnt - fb, oeb, ROWS, ROWS);
        end
        rb = rbit_q.size();
        k  = cyc;
        enable = 1'b1;
        wait_for(0, fs_cnt + 1, 100, ok);
        n = rbit_q.size() - rb;
        rbits = '0;
        for (int i = 0; i < n && i < ROWS; i++) rbits[i] = rbit_q[rb+i];
        vectors++;
        if (!ok || fs_last - k !== LEAD || n !== ROWS || rbits !== '0) begin
            errors++;
            $display("FAIL drop_reenable: got lead %0d edges %0d bits %b want %0d %0d zeros",
                     fs_last - k, n, rbits, LEAD, ROWS);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k;
        wait_for(0, fs_cnt + 1, 2*P*ROWS, ok);
        wait_for(3, 0, 2*COLS, ok);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (!ok || {oeb, cclk} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_shift: got oeb,cclk %b want 10", {oeb, cclk});
        end
        tick(2);
        k = cyc;
        reset_n = 1'b1;
        wait_for(0, fs_cnt + 1, 100, ok);
        vectors++;
        if (!ok || fs_last - k !== LEAD) begin
            errors++;
            $display("FAIL reset_mid_lead: got %0d want %0d", fs_last - k, LEAD);
        end
        wait_for(4, 0, 2*P, ok);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (!ok || oeb !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_display: got oeb %b want 1", oeb);
        end
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_row_walk();
        test_snapshot();
        test_enable_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
